// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default word width, read-side buffer depth and occupancy type.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned BUF_DEPTH  = 2;

  typedef logic [1:0] buf_cnt_t;

  // True when the buffer still has room for one more read once the in-flight word lands
  // and this cycle's pop (if any) has left.
  function automatic logic can_issue(buf_cnt_t cnt, logic inflight, logic pop);
    logic [2:0] occ;
    occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    return occ < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready word stream leaving the FIFO read controller.
interface fifo_stream_reader_if #(
  parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/skid_buf2.sv
// Two-entry ordered buffer; entry 0 is the head. The head register keeps the last
// delivered word when the buffer drains, so the output does not glitch back to 0.
module skid_buf2 import fifo_pkg::*; #(
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output buf_cnt_t         cnt,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  buf_cnt_t         cnt_q, cnt_d;
  logic             pop_eff;

  assign pop_eff = pop && (cnt_q != 2'd0);
  assign cnt     = cnt_q;
  assign head    = entry0_q;

  // Next-state: shift on pop, append at the tail on push, both together keep occupancy.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    cnt_d    = cnt_q;
    case ({push, pop_eff})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          entry0_d = push_data;
          cnt_d    = 2'd1;
        end else if (cnt_q == 2'd1) begin
          entry1_d = push_data;
          cnt_d    = 2'd2;
        end
      end
      2'b01: begin
        if (cnt_q == 2'd2) begin
          entry0_d = entry1_q;
        end
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          entry0_d = entry1_q;
          entry1_d = push_data;
        end else begin
          entry0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // State registers; buffered words are discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      cnt_q    <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      cnt_q    <= cnt_d;
    end
  end

  // A push into a full buffer without a pop would lose a word.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop_eff && (cnt_q == 2'd2)));
  assert property (@(posedge clk) disable iff (rst) cnt_q != 2'd3);

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues reads, tracks the one-cycle read
// latency and presents returned words as a full-throughput valid/ready stream.
module fifo_stream_reader import fifo_pkg::*; #(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 fifo_rd,
  fifo_stream_reader_if.master m,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  logic             inflight_q;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  buf_cnt_t         buf_cnt;
  logic [WIDTH-1:0] head;
  logic             valid;
  logic             pop;

  assign valid = (buf_cnt != 2'd0);
  assign pop   = valid && m.ready;

  // Read issue looks ahead at the pop so a full stream sustains one read per cycle.
  always_comb begin
    fifo_rd = en && !fifo_empty && can_issue(buf_cnt, inflight_q, pop);
  end

  // Delivered-word counter next state; wraps naturally.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  // In-flight flag mirrors last cycle's read; counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= fifo_rd;
      word_cnt_q <= word_cnt_d;
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_data),
    .pop       (pop),
    .cnt       (buf_cnt),
    .head      (head)
  );

  assign m.valid  = valid;
  assign m.data   = head;
  assign busy     = inflight_q || valid;
  assign word_cnt = word_cnt_q;

  // A returning word must always find a free slot.
  assert property (@(posedge clk) disable iff (rst) !(inflight_q && (buf_cnt == 2'd2)));

endmodule
